// File: rtl/fifo_arb_pkg.sv
// Shared types and default parameter values for the FIFO write arbiter.
package fifo_arb_pkg;

  // Arbiter FSM: waiting for a qualifying request, or locked to one owner.
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_NREQ     = 4;
  localparam int DEF_DEPTH    = 16;
  localparam int DEF_MIN_FREE = 4;
  localparam int DEF_TIMEOUT  = 15;

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Rotating-priority search: first asserted request starting one above the
// last owner, wrapping around.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  localparam int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] last,
  output logic [NREQ-1:0] winner,
  output logic            found
);

  logic [IDXW-1:0] cand;

  // Walk candidates last+1 .. last+NREQ (mod NREQ); the first hit wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDXW'((int'(last) + k) % NREQ);
      if (!found && req[cand]) begin
        winner[cand] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-locking round-robin arbiter feeding a single FIFO write port.
// A grant is taken only when enough FIFO space is free; the owner keeps the
// port until its last word, or until it stays silent for TIMEOUT cycles.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NREQ     = DEF_NREQ,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int MIN_FREE = DEF_MIN_FREE,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  localparam int LVLW = $clog2(DEPTH)
) (
  input  logic                  CLK,
  input  logic                  rst_in,
  input  logic [NREQ*WIDTH-1:0] req_data_in,
  input  logic [NREQ-1:0]       req_valid_in,
  input  logic [NREQ-1:0]       req_last_in,
  output logic [NREQ-1:0]       req_ready_out,
  output logic [WIDTH-1:0]      fifo_data_out,
  output logic                  fifo_wr_out,
  input  logic                  fifo_full_in,
  input  logic [LVLW-1:0]       fifo_fill_lvl_in,
  output logic [NREQ-1:0]       grant_out,
  output logic                  timeout_out
);

  localparam int IDXW = $clog2(NREQ);
  localparam int CNTW = $clog2(TIMEOUT + 1);

  arb_state_t      state, state_nxt;
  logic [IDXW-1:0] owner, owner_nxt;
  logic [IDXW-1:0] last_owner, last_nxt;
  logic [CNTW-1:0] idle_cnt, cnt_nxt;

  logic [NREQ-1:0] winner;
  logic            found;
  logic [IDXW-1:0] win_idx;
  logic [NREQ-1:0] owner_oh;
  logic [LVLW:0]   free_cnt;
  logic            space_ok;
  logic            in_burst;
  logic            owner_valid;
  logic            owner_last;
  logic            idle_hit;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .req    (req_valid_in),
    .last   (last_owner),
    .winner (winner),
    .found  (found)
  );

  // Free space in the FIFO, one slot always kept unused.
  assign free_cnt = (LVLW+1)'(DEPTH - 1) - {1'b0, fifo_fill_lvl_in};
  assign space_ok = (free_cnt >= (LVLW+1)'(MIN_FREE));

  // Reset masks every output in the same cycle, even mid-burst.
  assign in_burst    = (state == BURST) && !rst_in;
  assign owner_valid = req_valid_in[owner];
  assign owner_last  = req_last_in[owner];

  // Convert the picker's one-hot winner to an index for the owner register.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner[i]) win_idx = IDXW'(i);
    end
  end

  // One-hot view of the current owner.
  always_comb begin
    owner_oh        = '0;
    owner_oh[owner] = 1'b1;
  end

  // Route the owner's data to the FIFO write port.
  always_comb begin
    fifo_data_out = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == IDXW'(i)) fifo_data_out = req_data_in[i*WIDTH +: WIDTH];
    end
  end

  assign grant_out     = in_burst ? owner_oh : '0;
  assign req_ready_out = (in_burst && !fifo_full_in) ? owner_oh : '0;
  assign fifo_wr_out   = owner_valid & req_ready_out[owner];

  // The TIMEOUT-th consecutive silent cycle releases the port; a full FIFO
  // never counts as silence, so a stalled burst is held indefinitely.
  assign idle_hit    = in_burst && !fifo_full_in && !owner_valid &&
                       (idle_cnt == CNTW'(TIMEOUT - 1));
  assign timeout_out = idle_hit;

  // Next-state logic: grant from IDLE, release on last word or timeout.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last_owner;
    cnt_nxt   = idle_cnt;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (found && space_ok) begin
          state_nxt = BURST;
          owner_nxt = win_idx;
        end
      end
      BURST: begin
        if (fifo_wr_out && owner_last) begin
          state_nxt = IDLE;
          last_nxt  = owner;
          cnt_nxt   = '0;
        end else if (idle_hit) begin
          state_nxt = IDLE;
          last_nxt  = owner;
          cnt_nxt   = '0;
        end else if (fifo_wr_out || fifo_full_in) begin
          cnt_nxt = '0;
        end else if (!owner_valid) begin
          cnt_nxt = idle_cnt + CNTW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset points the search at requester 0 first.
  always_ff @(posedge CLK) begin
    if (rst_in) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= IDXW'(NREQ - 1);
      idle_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_nxt;
      idle_cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench with a write scoreboard for fifo_wr_arbiter.
module tb_fifo_wr_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int DEPTH = 16;
  localparam int LVLW  = $clog2(DEPTH);

  logic                  CLK = 1'b0;
  logic                  rst_in;
  logic [NREQ*WIDTH-1:0] req_data_in;
  logic [NREQ-1:0]       req_valid_in;
  logic [NREQ-1:0]       req_last_in;
  logic [NREQ-1:0]       req_ready_out;
  logic [WIDTH-1:0]      fifo_data_out;
  logic                  fifo_wr_out;
  logic                  fifo_full_in;
  logic [LVLW-1:0]       fifo_fill_lvl_in;
  logic [NREQ-1:0]       grant_out;
  logic                  timeout_out;

  fifo_wr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .DEPTH(DEPTH),
                    .MIN_FREE(4), .TIMEOUT(15)) dut (
    .CLK              (CLK),
    .rst_in           (rst_in),
    .req_data_in      (req_data_in),
    .req_valid_in     (req_valid_in),
    .req_last_in      (req_last_in),
    .req_ready_out    (req_ready_out),
    .fifo_data_out    (fifo_data_out),
    .fifo_wr_out      (fifo_wr_out),
    .fifo_full_in     (fifo_full_in),
    .fifo_fill_lvl_in (fifo_fill_lvl_in),
    .grant_out        (grant_out),
    .timeout_out      (timeout_out)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // Requester models: words remaining, next word number, enable, last mode.
  int       left [NREQ];
  int       seq  [NREQ];
  bit       en   [NREQ];
  bit       each_last [NREQ];
  logic     rst_q;
  logic     full_q;
  logic [LVLW-1:0] fill_q;

  // Scoreboard entry: {expected grant one-hot, expected data}.
  logic [NREQ+WIDTH-1:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int id, input logic [WIDTH-1:0] data);
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[id] = 1'b1;
    exp_q.push_back({oh, data});
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid_in[i] = en[i] && (left[i] > 0);
      req_last_in[i]  = each_last[i] || (left[i] == 1);
      req_data_in[i*WIDTH +: WIDTH] = {4'(i), 4'(seq[i])};
    end
    rst_in           = rst_q;
    fifo_full_in     = full_q;
    fifo_fill_lvl_in = fill_q;
  endtask

  // Called at a negedge: advance one clock, update requesters on handshake.
  task automatic step();
    logic [NREQ-1:0] acc;
    acc = req_valid_in & req_ready_out;
    @(posedge CLK);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) begin
        left[i]--;
        seq[i]++;
      end
    end
    drive();
    @(negedge CLK);
  endtask

  // Monitor: every FIFO write must match the next scoreboard entry.
  always @(negedge CLK) begin
    if (fifo_wr_out === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got grant %0h data %0h expected none",
                 grant_out, fifo_data_out);
      end else begin
        logic [NREQ+WIDTH-1:0] e;
        e = exp_q.pop_front();
        if ({grant_out, fifo_data_out} !== e) begin
          fails++;
          $display("FAIL write_data: got grant %0h data %0h expected grant %0h data %0h",
                   grant_out, fifo_data_out, e[NREQ+WIDTH-1:WIDTH], e[WIDTH-1:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0] rr_exp [4];
    int nw, nt, ng, t15;

    for (int i = 0; i < NREQ; i++) begin
      left[i] = 0; seq[i] = 0; en[i] = 1'b1; each_last[i] = 1'b1;
    end
    rst_q = 1'b1; full_q = 1'b0; fill_q = '0;
    req_data_in = '0; req_valid_in = '0; req_last_in = '0;
    drive();
    @(negedge CLK);
    @(negedge CLK);
    chk("reset_grant",   32'(grant_out), 0);
    chk("reset_ready",   32'(req_ready_out), 0);
    chk("reset_wr",      32'(fifo_wr_out), 0);
    chk("reset_timeout", 32'(timeout_out), 0);
    rst_q = 1'b0;
    drive();
    step();
    chk("idle_after_reset", 32'(grant_out), 0);

    // Round robin with single-word bursts from 0, 1, 3.
    left[0] = 2; left[1] = 1; left[3] = 1;
    drive();
    push(0, 8'h00); push(1, 8'h10); push(3, 8'h30); push(0, 8'h01);
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b1000; rr_exp[3] = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      chk("rr_idle_gap", 32'(grant_out), 0);
      step();
      chk("rr_grant", 32'(grant_out), 32'(rr_exp[k]));
      step();
    end

    // Burst lock: requester 2 sends five words while requester 0 waits.
    left[2] = 5; each_last[2] = 1'b0; left[0] = 1;
    drive();
    push(2, 8'h20); push(2, 8'h21); push(2, 8'h22); push(2, 8'h23); push(2, 8'h24);
    push(0, 8'h02);
    step();
    for (int k = 0; k < 5; k++) begin
      chk("lock_grant", 32'(grant_out), 32'h4);
      chk("lock_ready", 32'(req_ready_out), 32'h4);
      chk("lock_wr",    32'(fifo_wr_out), 1);
      step();
    end
    chk("lock_end_idle", 32'(grant_out), 0);
    step();
    chk("lock_next_grant", 32'(grant_out), 32'h1);
    step();

    // Free-space gate.
    fill_q = 12; left[1] = 1;
    drive();
    push(1, 8'h11);
    step();
    chk("gate_fill12_a", 32'(grant_out), 0);
    step();
    chk("gate_fill12_b", 32'(grant_out), 0);
    fill_q = 11;
    drive();
    step();
    chk("gate_fill11", 32'(grant_out), 32'h2);
    step();
    fill_q = 0;
    drive();

    // Full stall mid-burst for 30 cycles.
    left[3] = 4; each_last[3] = 1'b0;
    drive();
    push(3, 8'h31); push(3, 8'h32); push(3, 8'h33); push(3, 8'h34);
    step();
    chk("full_pre_grant", 32'(grant_out), 32'h8);
    full_q = 1'b1;
    step();
    nw = 0; nt = 0; ng = 0;
    for (int c = 1; c <= 30; c++) begin
      if (fifo_wr_out !== 1'b0) nw++;
      if (timeout_out !== 1'b0) nt++;
      if (grant_out !== 4'h8) ng++;
      if (c == 30) full_q = 1'b0;
      step();
    end
    chk("full_no_write",   32'(nw), 0);
    chk("full_no_timeout", 32'(nt), 0);
    chk("full_grant_held", 32'(ng), 0);
    chk("full_resume_wr",  32'(fifo_wr_out), 1);
    step(); step(); step();
    chk("full_burst_done", 32'(grant_out), 0);

    // Timeout: owner 0 goes silent after one word.
    left[0] = 3; each_last[0] = 1'b0; left[1] = 1;
    drive();
    push(0, 8'h03); push(1, 8'h12);
    step();
    chk("to_grant0", 32'(grant_out), 32'h1);
    en[0] = 1'b0;
    step();
    nt = 0; t15 = 0;
    for (int c = 1; c <= 15; c++) begin
      if (timeout_out === 1'b1) nt++;
      if (c == 15) t15 = int'(timeout_out);
      step();
    end
    if (timeout_out === 1'b1) nt++;
    chk("to_pulse_at_15", 32'(t15), 1);
    chk("to_pulse_once",  32'(nt), 1);
    chk("to_grant_off",   32'(grant_out), 0);
    step();
    chk("to_next_req", 32'(grant_out), 32'h2);
    step();
    left[0] = 0; en[0] = 1'b1;
    drive();

    // Reset during a write cycle of requester 2.
    left[2] = 4;
    drive();
    push(2, 8'h25); push(2, 8'h26);
    step();
    chk("rst_pre_grant", 32'(grant_out), 32'h4);
    step();
    rst_q = 1'b1; left[0] = 1; each_last[0] = 1'b1;
    push(0, 8'h04);
    step();
    chk("rst_wr",    32'(fifo_wr_out), 0);
    chk("rst_grant", 32'(grant_out), 0);
    chk("rst_ready", 32'(req_ready_out), 0);
    rst_q = 1'b0; en[2] = 1'b0;
    step();
    chk("rst_idle", 32'(grant_out), 0);
    step();
    chk("rst_first_grant", 32'(grant_out), 32'h1);
    step();
    step();
    step();
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: data width of every requester and of the FIFO write port.
REQ-002 Parameter NREQ, default 4: number of requesters; minimum 2.
REQ-003 Parameter DEPTH, default 16: attached FIFO depth; usable capacity is DEPTH-1 entries.
REQ-004 Parameter MIN_FREE, default 4: free entries required before a new grant is issued.
REQ-005 Parameter TIMEOUT, default 15: idle cycles inside a burst before a forced release.
REQ-006 CLK  in  1  the single clock; all state changes on its rising edge.
REQ-007 rst_in  in  1  synchronous, active-high reset.
REQ-008 req_data_in  in  NREQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
REQ-009 req_valid_in  in  NREQ  requester i has a word available.
REQ-010 req_last_in  in  NREQ  requester i current word ends its burst.
REQ-011 req_ready_out  out  NREQ  requester i word accepted this cycle when valid and ready are both high.
REQ-012 fifo_data_out  out  WIDTH  FIFO write data.
REQ-013 fifo_wr_out  out  1  FIFO write strobe.
REQ-014 fifo_full_in  in  1  FIFO full flag.
REQ-015 fifo_fill_lvl_in  in  $clog2(DEPTH)  FIFO occupancy.
REQ-016 grant_out  out  NREQ  one-hot current owner; all zero when idle.
REQ-017 timeout_out  out  1  one-cycle pulse on forced release.

Function
REQ-018 The FSM SHALL have two states: IDLE and BURST.
REQ-019 IDLE -> BURST SHALL occur when any req_valid_in bit is high and (DEPTH-1-fifo_fill_lvl_in) >= MIN_FREE.
REQ-020 The winner SHALL be the first valid requester found searching from (last owner + 1) mod NREQ upward, with wrap-around.
REQ-021 The grant SHALL be registered: grant_out asserts one cycle after the qualifying request, and no transfer occurs in IDLE.
REQ-022 In BURST, only req_ready_out[g] SHALL be driven, equal to ~fifo_full_in; all other ready bits stay 0.
REQ-023 fifo_wr_out SHALL equal req_valid_in[g] & req_ready_out[g] (combinational), and fifo_data_out SHALL equal requester g's data.
REQ-024 A transfer with req_last_in[g] high SHALL return the FSM to IDLE and record g as last owner.
REQ-025 The idle counter SHALL clear on every transfer or full cycle, and increment when req_valid_in[g] is low.
REQ-026 When the idle counter reaches TIMEOUT, the FSM SHALL return to IDLE, record g as last owner, and pulse timeout_out.
REQ-027 fifo_full_in high SHALL hold the burst indefinitely: no timeout and no write.
REQ-028 A new grant SHALL NOT issue in the same cycle the previous burst ends; IDLE lasts at least one cycle.
REQ-029 Requester valid changes outside the owner SHALL have no effect during BURST.

Reset
REQ-030 With rst_in high, the block SHALL enter IDLE and clear the idle counter, with last owner = NREQ-1 so the first search starts at requester 0.
REQ-031 With rst_in high, grant_out, req_ready_out, fifo_wr_out and timeout_out SHALL be 0 in the same cycle, including mid-burst; no partial write is issued.

Structure
REQ-032 Package fifo_arb_pkg SHALL hold the state enum (IDLE, BURST) and the default parameter constants.
REQ-033 Sub-module rr_picker SHALL contain the combinational rotate-priority search (inputs: request vector, last owner; outputs: one-hot winner, found flag).
REQ-034 Expected RTL size is 120-400 lines; no RAM is instantiated.

Verification
REQ-035 Round robin: requesters 0, 1 and 3 valid with single-word bursts (last=1), FIFO empty -> grant order 0, 1, 3, 0, with an IDLE cycle between each grant.
REQ-036 Burst lock: requester 2 sends 5 words with last on word 5 while requester 0 stays valid -> 5 consecutive writes from requester 2 before requester 0 is granted.
REQ-037 Free-space gate: fill_lvl=12 with DEPTH=16 and MIN_FREE=4 -> no grant; fill_lvl=11 -> grant asserts the next cycle.
REQ-038 Full stall: fifo_full_in high for 30 cycles mid-burst -> fifo_wr_out=0, no timeout, and the burst resumes when full drops.
REQ-039 Timeout: the owner drops valid for 15 cycles -> timeout_out pulses once, grant_out=0, and the next grant goes to the next requester.
REQ-040 Reset mid-burst: rst_in high during a write cycle -> fifo_wr_out=0 that cycle, and after release the first grant goes to requester 0.
